instr_loader: RTL and testbench

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/mips_pkg.sv | 20 ++
 rtl/word_assembler.sv | 32 +++
 rtl/instr_loader.sv | 123 ++++++++++++
 tb/tb_instr_loader.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared loader definitions: FSM state encoding and stream framing constants.
package mips_pkg;

  localparam int unsigned HDR_BYTES  = 2;
  localparam int unsigned WORD_BYTES = 4;

  typedef logic [2:0] loaderState_t;

  localparam loaderState_t StHdrHi = 3'd0;
  localparam loaderState_t StHdrLo = 3'd1;
  localparam loaderState_t StData  = 3'd2;
  localparam loaderState_t StChk   = 3'd3;
  localparam loaderState_t StDone  = 3'd4;
  localparam loaderState_t StError = 3'd5;

  function automatic logic stateAcceptsByte(input loaderState_t s);
    return (s == StHdrHi) || (s == StHdrLo) || (s == StData) || (s == StChk);
  endfunction

endpackage

// File: rtl/word_assembler.sv
// Collects big-endian program bytes into 32-bit words; wordDone flags the byte that completes a word.
module word_assembler
  import mips_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    byteEn,
  input  logic [7:0]              byteData,
  output logic [8*WORD_BYTES-1:0] word,
  output logic                    wordDone
);

  localparam int unsigned CntW = $clog2(WORD_BYTES);

  logic [CntW-1:0]               byteCntQ;
  logic [8*(WORD_BYTES-1)-1:0]   shiftQ;

  // The completing byte is merged combinationally so the top can register the word on that edge.
  assign word     = {shiftQ, byteData};
  assign wordDone = byteEn && (byteCntQ == CntW'(WORD_BYTES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      byteCntQ <= '0;
      shiftQ   <= '0;
    end else if (byteEn) begin
      byteCntQ <= byteCntQ + CntW'(1);
      shiftQ   <= {shiftQ[8*(WORD_BYTES-2)-1:0], byteData};
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Streams a length-prefixed program into instruction memory and holds the CPU in reset until done.
// Optional trailer checksum enabled by defining LOADER_CHECKSUM_EN.
module instr_loader
  import mips_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  byteData,
  input  logic        byteValid,
  output logic        byteReady,
  output logic        imemWe,
  output logic [31:0] imemAddr,
  output logic [31:0] imemWdata,
  output logic        cpuReset,
  output logic        done,
  output logic        error
);

  loaderState_t                stateQ, stateD;
  logic [8*(HDR_BYTES-1)-1:0]  hdrHiQ;
  logic [15:0]                 hdrCount;
  logic [15:0]                 nWordsQ;
  logic [15:0]                 wordIdxQ;
  logic                        xfer;
  logic                        lastWord;
  logic [31:0]                 word;
  logic                        wordDone;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]                  chkQ;
`endif

  assign xfer     = byteValid && byteReady;
  assign hdrCount = {hdrHiQ, byteData};
  assign lastWord = (wordIdxQ == nWordsQ - 16'd1);

  word_assembler uAsm (
    .clk      (clk),
    .reset    (reset),
    .byteEn   (xfer && (stateQ == StData)),
    .byteData (byteData),
    .word     (word),
    .wordDone (wordDone)
  );

  always_comb begin
    stateD = stateQ;
    case (stateQ)
      StHdrHi: if (xfer) stateD = StHdrLo;
      StHdrLo: begin
        if (xfer) begin
          if (hdrCount == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
            stateD = StChk;
`else
            stateD = StDone;
`endif
          end else if ({1'b0, hdrCount} > 17'(MEM_WORDS)) begin
            stateD = StError;
          end else begin
            stateD = StData;
          end
        end
      end
      StData: begin
        if (wordDone && lastWord) begin
`ifdef LOADER_CHECKSUM_EN
          stateD = StChk;
`else
          stateD = StDone;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      StChk: if (xfer) stateD = (byteData == chkQ) ? StDone : StError;
`endif
      default: stateD = stateQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ    <= StHdrHi;
      hdrHiQ    <= '0;
      nWordsQ   <= '0;
      wordIdxQ  <= '0;
      byteReady <= 1'b0;
      imemWe    <= 1'b0;
      imemAddr  <= '0;
      imemWdata <= '0;
      cpuReset  <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      stateQ    <= stateD;
      byteReady <= stateAcceptsByte(stateD);
      cpuReset  <= (stateD != StDone);
      done      <= (stateD == StDone);
      error     <= (stateD == StError);
      imemWe    <= wordDone;
      if (xfer && (stateQ == StHdrHi)) hdrHiQ <= byteData;
      if (xfer && (stateQ == StHdrLo)) nWordsQ <= hdrCount;
      if (wordDone) begin
        imemAddr  <= {14'd0, wordIdxQ, 2'b00};
        imemWdata <= word;
        wordIdxQ  <= wordIdxQ + 16'd1;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running XOR over header and payload; the trailer byte itself is excluded.
  always_ff @(posedge clk) begin
    if (reset) begin
      chkQ <= '0;
    end else if (xfer && (stateQ != StChk)) begin
      chkQ <= chkQ ^ byteData;
    end
  end
`endif

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: directed streams plus randomized streams vs a stream-level model.
module tb_instr_loader;

  localparam int MEM_WORDS = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  byteData = '0;
  logic        byteValid = 1'b0;
  logic        byteReady;
  logic        imemWe;
  logic [31:0] imemAddr;
  logic [31:0] imemWdata;
  logic        cpuReset;
  logic        done;
  logic        error;

  int tests = 0;
  int fails = 0;

  logic [7:0]  strm[$];
  logic [31:0] words[$];
  logic [63:0] expW[$];
  logic [63:0] wr[$];
  int          expConsumed;
  bit          expDone;

  instr_loader #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk       (clk),
    .reset     (reset),
    .byteData  (byteData),
    .byteValid (byteValid),
    .byteReady (byteReady),
    .imemWe    (imemWe),
    .imemAddr  (imemAddr),
    .imemWdata (imemWdata),
    .cpuReset  (cpuReset),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (imemWe === 1'b1) wr.push_back({imemAddr, imemWdata});

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    byteValid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b, output bit ok);
    int t;
    t = 0;
    @(negedge clk);
    byteValid = 1'b1;
    byteData  = b;
    while (byteReady !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    ok = (byteReady === 1'b1);
    if (ok) @(posedge clk);
    #1;
    byteValid = 1'b0;
  endtask

  // Builds header + payload (+ XOR trailer when the checksum build is selected).
  task automatic makeStream(input int n, input bit corrupt);
    logic [7:0] x;
    strm.delete();
    strm.push_back(8'((n >> 8) & 255));
    strm.push_back(8'(n & 255));
    foreach (words[k]) begin
      strm.push_back(words[k][31:24]);
      strm.push_back(words[k][23:16]);
      strm.push_back(words[k][15:8]);
      strm.push_back(words[k][7:0]);
    end
`ifdef LOADER_CHECKSUM_EN
    x = '0;
    foreach (strm[i]) x ^= strm[i];
    strm.push_back(corrupt ? (x ^ 8'h01) : x);
`else
    if (corrupt) strm.push_back(8'hFF);
`endif
  endtask

  // Reference: decode the stream by its framing rules, independent of the loader's FSM.
  task automatic modelStream();
    int n;
    logic [7:0] x;
    expW.delete();
    n = int'({strm[0], strm[1]});
    expConsumed = 2;
    expDone = 1'b1;
    if (n > MEM_WORDS) begin
      expDone = 1'b0;
      return;
    end
    for (int k = 0; k < n; k++)
      expW.push_back({32'(4 * k), strm[2+4*k], strm[3+4*k], strm[4+4*k], strm[5+4*k]});
    expConsumed = 2 + 4 * n;
`ifdef LOADER_CHECKSUM_EN
    x = '0;
    for (int i = 0; i < expConsumed; i++) x ^= strm[i];
    expDone = (strm[expConsumed] == x);
    expConsumed++;
`endif
  endtask

  task automatic runStream(input string name, input int gap);
    bit ok;
    doReset();
    wr.delete();
    modelStream();
    for (int i = 0; i < expConsumed; i++) begin
      if (i > 0) repeat (gap) @(negedge clk);
      sendByte(strm[i], ok);
      tests++;
      if (!ok) begin
        fails++;
        $display("FAIL %s stall: byteReady low at byte %0d, required 1", name, i);
        break;
      end
      if (i < expConsumed - 1) begin
        tests++;
        if (cpuReset !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
          fails++;
          $display("FAIL %s midload: cpuReset=%b done=%b error=%b, required 1 0 0", name,
                   cpuReset, done, error);
        end
      end
    end
    @(negedge clk);
    tests++;
    if (done !== expDone || error !== !expDone || cpuReset !== !expDone || byteReady !== 1'b0) begin
      fails++;
      $display("FAIL %s outcome: done=%b error=%b cpuReset=%b byteReady=%b, required %b %b %b 0",
               name, done, error, cpuReset, byteReady, expDone, !expDone, !expDone);
    end
    // Bytes offered after termination must be ignored.
    repeat (3) begin
      byteValid = 1'b1;
      byteData  = 8'($urandom);
      @(negedge clk);
    end
    byteValid = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (done !== expDone || error !== !expDone) begin
      fails++;
      $display("FAIL %s terminal: done=%b error=%b, required %b %b", name, done, error,
               expDone, !expDone);
    end
    tests++;
    if (wr.size() != expW.size()) begin
      fails++;
      $display("FAIL %s writecount: got %0d, required %0d", name, wr.size(), expW.size());
    end else begin
      foreach (expW[i]) begin
        tests++;
        if (wr[i] !== expW[i]) begin
          fails++;
          $display("FAIL %s write%0d: got %h@%h, required %h@%h", name, i, wr[i][31:0],
                   wr[i][63:32], expW[i][31:0], expW[i][63:32]);
        end
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if (byteReady !== 1'b0 || imemWe !== 1'b0 || imemAddr !== 32'd0 || imemWdata !== 32'd0 ||
        cpuReset !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
      fails++;
      $display("FAIL reset_values: rdy=%b we=%b addr=%h wdata=%h cpuRst=%b done=%b err=%b", byteReady,
               imemWe, imemAddr, imemWdata, cpuReset, done, error);
    end
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if (byteReady !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: byteReady=%b, required 1", byteReady);
    end
  endtask

  task automatic test_directed();
    words = '{32'h20080005, 32'h01095020};
    makeStream(2, 1'b0);
    runStream("twoWords", 0);
    runStream("twoWordsGap5", 5);
`ifdef LOADER_CHECKSUM_EN
    makeStream(2, 1'b1);
    runStream("twoWordsBadChk", 0);
`endif
  endtask

  task automatic test_boundaries();
    words.delete();
    makeStream(16'h0041, 1'b0);
    runStream("oversize", 0);
    makeStream(0, 1'b0);
    runStream("empty", 0);
`ifdef LOADER_CHECKSUM_EN
    makeStream(0, 1'b1);
    runStream("emptyBadChk", 0);
`endif
    for (int k = 0; k < MEM_WORDS; k++) words.push_back($urandom);
    makeStream(MEM_WORDS, 1'b0);
    runStream("fullMem", 0);
  endtask

  task automatic test_reset_midload();
    bit ok;
    logic [7:0] part[$];
    part = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09};
    doReset();
    wr.delete();
    foreach (part[i]) sendByte(part[i], ok);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (wr.size() != 1 || wr[0] !== {32'h0, 32'h20080005}) begin
      fails++;
      $display("FAIL midload_partial: %0d writes, required exactly 20080005@0", wr.size());
    end
    words = '{32'hDEADBEEF, 32'h01095020};
    makeStream(2, 1'b0);
    runStream("resend", 0);
    tests++;
    if (wr.size() == 0 || wr[0] !== {32'h0, 32'hDEADBEEF}) begin
      fails++;
      $display("FAIL resend_mem0: got %h, required deadbeef", wr.size() ? wr[0][31:0] : 32'hx);
    end
  endtask

  task automatic test_reset_priority();
    bit ok;
    logic [7:0] part[$];
    part = '{8'h00, 8'h01, 8'h20, 8'h08, 8'h00};
    doReset();
    wr.delete();
    foreach (part[i]) sendByte(part[i], ok);
    @(negedge clk);
    byteValid = 1'b1;
    byteData  = 8'h05;
    reset = 1'b1;
    @(negedge clk);
    byteValid = 1'b0;
    reset = 1'b0;
    tests++;
    if (byteReady !== 1'b0) begin
      fails++;
      $display("FAIL prio_ready: byteReady=%b, required 0", byteReady);
    end
    repeat (2) @(negedge clk);
    tests++;
    if (wr.size() != 0) begin
      fails++;
      $display("FAIL prio_nowrite: got %0d writes, required 0", wr.size());
    end
  endtask

  task automatic test_random();
    int n;
    bit bad;
    for (int it = 0; it < 20; it++) begin
      n = $urandom_range(0, 70);
      words.delete();
      if (n <= MEM_WORDS) for (int k = 0; k < n; k++) words.push_back($urandom);
`ifdef LOADER_CHECKSUM_EN
      bad = ($urandom_range(0, 3) == 0);
`else
      bad = 1'b0;
`endif
      makeStream(n, bad);
      runStream($sformatf("rand%0d", it), $urandom_range(0, 2));
    end
  endtask

  initial begin
    fork
      begin
        #5ms;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
      end
    join_none
    test_reset();
    test_directed();
    test_boundaries();
    test_reset_midload();
    test_reset_priority();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
